// File: rtl/syscall_ctrl.sv
// syscall_ctrl: services MIPS syscall in EX (print int/string, exit), freezing the pipeline.
// Build option: define SYSCALL_PRINT_CHAR_EN to add the print-char service (code 11).
module syscall_ctrl #(
  parameter logic [31:0] STR_LO    = 32'h00400000,
  parameter logic [31:0] STR_HI    = 32'h00400400,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sys_req,
  input  logic [31:0] regv,
  input  logic [31:0] rega,
  output logic        stall,
  output logic        done,
  output logic        mem_rd,
  output logic [29:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [7:0]  char_out,
  output logic        char_valid,
  input  logic        char_ready,
  output logic [31:0] int_out,
  output logic        int_valid,
  output logic        err,
  output logic        exit_out
);

  localparam int unsigned CntW = $clog2(MAX_WORDS) + 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_WORDS);

  typedef enum logic [2:0] {
    StIdle, StInt, StFetch, StLatch, StEmit, StDone, StHalt, StPchar
  } state_e;

  state_e          state_q, state_d;
  logic            armed_q, armed_d;
  logic            err_q, err_d;
  logic [31:0]     arg_q, arg_d;
  logic [29:0]     loc_q, loc_d;
  logic [CntW-1:0] word_cnt_q, word_cnt_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [31:0]     word_buf_q, word_buf_d;
  logic [7:0]      cur_byte;
  logic            accept;
  logic            ptr_ok;

  always_comb begin
    unique case (byte_idx_q)
      2'd0: cur_byte = word_buf_q[7:0];
      2'd1: cur_byte = word_buf_q[15:8];
      2'd2: cur_byte = word_buf_q[23:16];
      2'd3: cur_byte = word_buf_q[31:24];
      default: cur_byte = 8'h00;
    endcase
  end

  // A held sys_req gets one service: armed only re-sets after sys_req is seen low in idle.
  assign accept = (state_q == StIdle) && sys_req && armed_q;
  assign ptr_ok = (rega > STR_LO) && (rega < STR_HI);

  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    err_d      = 1'b0;
    arg_d      = arg_q;
    loc_d      = loc_q;
    word_cnt_d = word_cnt_q;
    byte_idx_d = byte_idx_q;
    word_buf_d = word_buf_q;
    case (state_q)
      StIdle: begin
        if (!sys_req) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          arg_d = rega;
          if (regv == 32'd1) begin
            state_d = StInt;
          end else if (regv == 32'd4) begin
            if (ptr_ok) begin
              state_d    = StFetch;
              loc_d      = rega[31:2];
              word_cnt_d = '0;
            end else begin
              state_d = StDone;
              err_d   = 1'b1;
            end
          end else if (regv == 32'd10) begin
            state_d = StHalt;
`ifdef SYSCALL_PRINT_CHAR_EN
          end else if (regv == 32'd11) begin
            state_d = StPchar;
`endif
          end else begin
            state_d = StDone;
          end
        end
      end
      StInt:   state_d = StDone;
      StFetch: state_d = StLatch;
      StLatch: begin
        word_buf_d = mem_rdata;
        byte_idx_d = 2'd0;
        word_cnt_d = word_cnt_q + CntW'(1);
        state_d    = StEmit;
      end
      StEmit: begin
        if (cur_byte == 8'h00) begin
          state_d = StDone;
        end else if (char_ready) begin
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            if (word_cnt_q == MaxCnt) begin
              state_d = StDone;
              err_d   = 1'b1;
            end else begin
              loc_d   = loc_q + 30'd1;
              state_d = StFetch;
            end
          end
        end
      end
      StDone: begin
        armed_d = 1'b0;
        state_d = StIdle;
      end
      StHalt: state_d = StHalt;
      StPchar: begin
`ifdef SYSCALL_PRINT_CHAR_EN
        if (char_ready) state_d = StDone;
`else
        state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      armed_q    <= 1'b1;
      err_q      <= 1'b0;
      arg_q      <= '0;
      loc_q      <= '0;
      word_cnt_q <= '0;
      byte_idx_q <= '0;
      word_buf_q <= '0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      err_q      <= err_d;
      arg_q      <= arg_d;
      loc_q      <= loc_d;
      word_cnt_q <= word_cnt_d;
      byte_idx_q <= byte_idx_d;
      word_buf_q <= word_buf_d;
    end
  end

  // Outputs decode registered state only, so they hold steady under backpressure.
  assign stall      = ((state_q != StIdle) && (state_q != StDone)) || accept;
  assign done       = (state_q == StDone);
  assign err        = err_q;
  assign exit_out   = (state_q == StHalt);
  assign int_valid  = (state_q == StInt);
  assign int_out    = int_valid ? arg_q : 32'h0;
  assign mem_rd     = (state_q == StFetch);
  assign mem_addr   = mem_rd ? loc_q : 30'h0;

  always_comb begin
    char_out   = 8'h00;
    char_valid = 1'b0;
    if (state_q == StEmit) begin
      char_out   = cur_byte;
      char_valid = (cur_byte != 8'h00);
    end else if (state_q == StPchar) begin
      char_out   = arg_q[7:0];
      char_valid = 1'b1;
    end
  end

endmodule

// File: tb/tb_syscall_ctrl.sv
// tb_syscall_ctrl: directed, table-driven bench for syscall_ctrl with a small memory model.
module tb_syscall_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sys_req = 1'b0;
  logic        sys_req2 = 1'b0;
  logic        char_ready = 1'b1;
  logic [31:0] regv = 32'h0;
  logic [31:0] rega = 32'h0;
  logic [31:0] mem_rdata = 32'h0;

  logic        stall, done, mem_rd, char_valid, int_valid, err, exit_out;
  logic [29:0] mem_addr;
  logic [7:0]  char_out;
  logic [31:0] int_out;

  logic        stall2, done2, mem_rd2, char_valid2, int_valid2, err2, exit_out2;
  logic [29:0] mem_addr2;
  logic [7:0]  char_out2;
  logic [31:0] int_out2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  syscall_ctrl dut (
    .clk(clk), .reset(reset), .sys_req(sys_req), .regv(regv), .rega(rega),
    .stall(stall), .done(done), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .char_out(char_out), .char_valid(char_valid),
    .char_ready(char_ready), .int_out(int_out), .int_valid(int_valid),
    .err(err), .exit_out(exit_out)
  );

  syscall_ctrl #(.MAX_WORDS(2)) dut2 (
    .clk(clk), .reset(reset), .sys_req(sys_req2), .regv(regv), .rega(rega),
    .stall(stall2), .done(done2), .mem_rd(mem_rd2), .mem_addr(mem_addr2),
    .mem_rdata(32'h41414141), .char_out(char_out2), .char_valid(char_valid2),
    .char_ready(char_ready), .int_out(int_out2), .int_valid(int_valid2),
    .err(err2), .exit_out(exit_out2)
  );

  logic [76:0] outs_all;
  assign outs_all = {stall, done, mem_rd, mem_addr, char_out, char_valid, int_out, int_valid,
                     err, exit_out};

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    case (a)
      30'h00100004: return 32'h6C6C6548;
      30'h00100005: return 32'h0000216F;
      default:      return 32'h00000000;
    endcase
  endfunction

  always @(posedge clk) if (mem_rd) mem_rdata <= mem_word(mem_addr);

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          n_int;
    logic [31:0] int_val;
    int          n_chars;
    logic [63:0] chars;
    int          n_rd;
    logic [59:0] addrs;
    int          n_err;
    int          done_cyc;
    logic        stall0;
    logic        stall_done;
    int          holds;
    logic [7:0]  hold_char;
    int          hold_bad;
  } res_t;

  typedef struct {
    logic [31:0] v;
    logic [31:0] a;
    int          n_int;
    logic [31:0] int_val;
    int          n_chars;
    logic [63:0] chars;
    int          n_rd;
    int          n_err;
    int          done_cyc;
  } vec_t;

  // Issues one call and logs every event until done; bp_at/bp_len hold char_ready low.
  task automatic run_call(input logic [31:0] v, input logic [31:0] a, input int bp_at,
                          input int bp_len, output res_t r);
    int bp_done;
    bp_done = 0;
    r.n_int = 0; r.int_val = '0; r.n_chars = 0; r.chars = '0; r.n_rd = 0; r.addrs = '0;
    r.n_err = 0; r.done_cyc = 0; r.stall0 = 1'b0; r.stall_done = 1'b1; r.holds = 0;
    r.hold_char = '0; r.hold_bad = 0;
    sys_req = 1'b0;
    char_ready = 1'b1;
    repeat (2) @(negedge clk);
    regv = v;
    rega = a;
    sys_req = 1'b1;
    #1 r.stall0 = stall;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      char_ready = 1'b1;
      if (char_valid && r.n_chars == bp_at && bp_done < bp_len) begin
        char_ready = 1'b0;
        if (bp_done == 0) r.hold_char = char_out;
        else if (char_out !== r.hold_char) r.hold_bad++;
        if (!stall) r.hold_bad++;
        bp_done++;
        r.holds++;
      end
      if (int_valid) begin r.n_int++; r.int_val = int_out; end
      if (char_valid && char_ready) begin r.chars = {r.chars[55:0], char_out}; r.n_chars++; end
      if (mem_rd) begin r.n_rd++; r.addrs = {r.addrs[29:0], mem_addr}; end
      if (err) r.n_err++;
      if (done) begin r.done_cyc = cyc; r.stall_done = stall; break; end
    end
    sys_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    res_t r;
    int   nd, ni, nc, ne, nr, dc;
    logic [63:0] ch;

    vecs.push_back('{32'd1, 32'hFFFFFFFB, 1, 32'hFFFFFFFB, 0, 64'h0, 0, 0, 2});
    vecs.push_back('{32'd1, 32'h00000000, 1, 32'h00000000, 0, 64'h0, 0, 0, 2});
    vecs.push_back('{32'd4, 32'h00400010, 0, 32'h0, 6, 64'h48656C6C6F21, 2, 0, 12});
    vecs.push_back('{32'd4, 32'h00400400, 0, 32'h0, 0, 64'h0, 0, 1, 1});
    vecs.push_back('{32'd4, 32'h00400000, 0, 32'h0, 0, 64'h0, 0, 1, 1});
    vecs.push_back('{32'd4, 32'h00400020, 0, 32'h0, 0, 64'h0, 1, 0, 4});
    vecs.push_back('{32'd7, 32'h00000000, 0, 32'h0, 0, 64'h0, 0, 0, 1});
    vecs.push_back('{32'h101, 32'h00000001, 0, 32'h0, 0, 64'h0, 0, 0, 1});
`ifdef SYSCALL_PRINT_CHAR_EN
    vecs.push_back('{32'd11, 32'h00000041, 0, 32'h0, 1, 64'h41, 0, 0, 2});
`else
    vecs.push_back('{32'd11, 32'h00000041, 0, 32'h0, 0, 64'h0, 0, 0, 1});
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("reset.outputs", outs_all, '0);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset.outputs", outs_all, '0);

    foreach (vecs[i]) begin
      run_call(vecs[i].v, vecs[i].a, -1, 0, r);
      check($sformatf("vec%0d.stall_req", i), r.stall0, 1);
      check($sformatf("vec%0d.n_int", i), r.n_int, vecs[i].n_int);
      check($sformatf("vec%0d.int_out", i), r.int_val, vecs[i].int_val);
      check($sformatf("vec%0d.n_chars", i), r.n_chars, vecs[i].n_chars);
      check($sformatf("vec%0d.chars", i), r.chars, vecs[i].chars);
      check($sformatf("vec%0d.n_rd", i), r.n_rd, vecs[i].n_rd);
      check($sformatf("vec%0d.n_err", i), r.n_err, vecs[i].n_err);
      check($sformatf("vec%0d.done_cyc", i), r.done_cyc, vecs[i].done_cyc);
      check($sformatf("vec%0d.stall_at_done", i), r.stall_done, 0);
    end

    // Backpressure on the third char of "Hello!"
    run_call(32'd4, 32'h00400010, 2, 5, r);
    check("bp.chars", r.chars, 64'h48656C6C6F21);
    check("bp.n_rd", r.n_rd, 2);
    check("bp.addrs", r.addrs, {30'h00100004, 30'h00100005});
    check("bp.holds", r.holds, 5);
    check("bp.hold_char", r.hold_char, 8'h6C);
    check("bp.hold_stable", r.hold_bad, 0);
    check("bp.done_cyc", r.done_cyc, 17);
    check("bp.n_err", r.n_err, 0);

    // Runaway guard on the MAX_WORDS=2 instance
    repeat (2) @(negedge clk);
    regv = 32'd4; rega = 32'h00400010; char_ready = 1'b1; sys_req2 = 1'b1;
    nc = 0; ne = 0; nr = 0; dc = 0; ch = '0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      if (char_valid2) begin ch = {ch[55:0], char_out2}; nc++; end
      if (mem_rd2) nr++;
      if (err2) ne++;
      if (done2) begin dc = cyc; break; end
    end
    sys_req2 = 1'b0;
    check("runaway.n_chars", nc, 8);
    check("runaway.chars", ch, 64'h4141414141414141);
    check("runaway.n_rd", nr, 2);
    check("runaway.n_err", ne, 1);
    check("runaway.done_cyc", dc, 13);

    // Held sys_req gives one service; a one-cycle drop rearms
    repeat (2) @(negedge clk);
    regv = 32'd1; rega = 32'd5; sys_req = 1'b1;
    nd = 0; ni = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) nd++;
      if (int_valid) ni++;
    end
    check("rearm.held_done", nd, 1);
    check("rearm.held_int", ni, 1);
    sys_req = 1'b0;
    @(negedge clk);
    sys_req = 1'b1;
    nd = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("rearm.second_done", nd, 1);
    sys_req = 1'b0;

    // Asynchronous reset in the middle of a string
    repeat (2) @(negedge clk);
    regv = 32'd4; rega = 32'h00400010; sys_req = 1'b1; char_ready = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (char_valid) break;
    end
    check("rst_emit.reached", char_valid, 1);
    #2 reset = 1'b1; sys_req = 1'b0;
    #1 check("rst_emit.outputs", outs_all, '0);
    @(negedge clk);
    reset = 1'b0;
    run_call(32'd1, 32'd7, -1, 0, r);
    check("rst_emit.next_call_int", r.int_val, 32'd7);
    check("rst_emit.next_call_done", r.done_cyc, 2);

    // Exit is sticky and ignores later requests
    repeat (2) @(negedge clk);
    regv = 32'd10; rega = 32'd0; sys_req = 1'b1;
    repeat (3) @(negedge clk);
    check("halt.exit", exit_out, 1);
    check("halt.stall", stall, 1);
    sys_req = 1'b0;
    repeat (2) @(negedge clk);
    regv = 32'd1; rega = 32'd9; sys_req = 1'b1;
    nd = 0; ni = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) nd++;
      if (int_valid) ni++;
    end
    check("halt.ignored_done", nd, 0);
    check("halt.ignored_int", ni, 0);
    check("halt.exit_sticky", {exit_out, stall}, 2'b11);
    sys_req = 1'b0;
    #2 reset = 1'b1;
    #1 check("halt.reset_outputs", outs_all, '0);
    @(negedge clk);
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
